// File: rtl/tage_pred_ctrl.sv
// TAGE predictor controller: hashes PC/history into per-table index and tag, picks the
// provider prediction, tracks in-flight branches in order and drives table updates on resolve.
module tage_pred_ctrl #(
    parameter int NUM_TABLES = 4,
    parameter int GHIST_LEN  = 32,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 8,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IN_reqValid,
    input  logic [31:0]                   IN_reqPC,
    input  logic                          IN_baseTaken,
    output logic                          OUT_reqReady,
    output logic                          OUT_predValid,
    output logic                          OUT_predTaken,
    output logic [$clog2(DEPTH)-1:0]      OUT_predId,
    input  logic                          IN_resValid,
    input  logic                          IN_resTaken,
    output logic [NUM_TABLES*IDX_W-1:0]   OUT_rdAddr,
    output logic [NUM_TABLES*TAG_W-1:0]   OUT_rdTag,
    input  logic [NUM_TABLES-1:0]         IN_rdValid,
    input  logic [NUM_TABLES-1:0]         IN_rdTaken,
    output logic [NUM_TABLES*IDX_W-1:0]   OUT_wrAddr,
    output logic [NUM_TABLES*TAG_W-1:0]   OUT_wrTag,
    output logic [NUM_TABLES-1:0]         OUT_wrTaken,
    output logic [NUM_TABLES-1:0]         OUT_wrValid,
    output logic [NUM_TABLES-1:0]         OUT_wrNew,
    output logic [NUM_TABLES-1:0]         OUT_wrUseful,
    output logic [NUM_TABLES-1:0]         OUT_wrUpdate,
    input  logic [NUM_TABLES-1:0]         IN_wrAlloc,
    output logic                          OUT_anyAlloc
);
    localparam int ID_W  = $clog2(DEPTH);
    localparam int CNT_W = ID_W + 1;
    localparam int AW    = NUM_TABLES * IDX_W;
    localparam int TW    = NUM_TABLES * TAG_W;

    // XOR-fold the low len bits of h into w-bit chunks
    function automatic logic [GHIST_LEN-1:0] fold(input logic [GHIST_LEN-1:0] h,
                                                  input int len, input int w);
        logic [GHIST_LEN-1:0] one;
        logic [GHIST_LEN-1:0] hm;
        logic [GHIST_LEN-1:0] wm;
        logic [GHIST_LEN-1:0] r;
        one = GHIST_LEN'(1);
        hm  = h & ((one << len) - one);
        wm  = (one << w) - one;
        r   = '0;
        for (int c = 0; c < GHIST_LEN; c += w)
            r = r ^ ((hm >> c) & wm);
        return r;
    endfunction

    logic [GHIST_LEN-1:0]  hist_q, hist_d;
    logic [ID_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  pred_valid_q, pred_taken_q;
    logic [ID_W-1:0]       pred_id_q;

    logic [AW-1:0]         q_idx_q  [DEPTH];
    logic [TW-1:0]         q_tag_q  [DEPTH];
    logic [NUM_TABLES-1:0] q_prov_q [DEPTH];
    logic                  q_ptk_q  [DEPTH];
    logic                  q_fin_q  [DEPTH];
    logic [GHIST_LEN-1:0]  q_snap_q [DEPTH];

    logic [AW-1:0]         rd_addr;
    logic [TW-1:0]         rd_tag;

    for (genvar t = 0; t < NUM_TABLES; t++) begin : g_hash
        localparam int L = GHIST_LEN >> (NUM_TABLES - 1 - t);
        assign rd_addr[t*IDX_W +: IDX_W] =
            IN_reqPC[IDX_W+1:2] ^ IDX_W'(fold(hist_q, L, IDX_W));
        assign rd_tag[t*TAG_W +: TAG_W] =
            IN_reqPC[IDX_W+TAG_W+1:IDX_W+2] ^ TAG_W'(fold(hist_q, L, TAG_W));
    end

    assign OUT_rdAddr = rd_addr;
    assign OUT_rdTag  = rd_tag;

    // Provider is the highest-numbered table that hits
    logic [NUM_TABLES-1:0] prov_oh;
    logic                  prov_tk;
    logic                  pred;
    always_comb begin
        prov_oh = '0;
        prov_tk = 1'b0;
        pred    = IN_baseTaken;
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (IN_rdValid[t]) begin
                prov_oh    = '0;
                prov_oh[t] = 1'b1;
                prov_tk    = IN_rdTaken[t];
                pred       = IN_rdTaken[t];
            end
        end
    end

    logic                  full, accept, res, mispred, push;
    logic [NUM_TABLES-1:0] h_prov, amask;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign accept  = IN_reqValid && !full;
    assign res     = IN_resValid && (count_q != '0);
    assign h_prov  = q_prov_q[rd_ptr_q];
    assign mispred = res && (q_fin_q[rd_ptr_q] != IN_resTaken);
    assign push    = accept && !mispred;

    assign OUT_reqReady  = !full;
    assign OUT_predValid = pred_valid_q;
    assign OUT_predTaken = pred_taken_q;
    assign OUT_predId    = pred_id_q;

    // Allocation targets every table above the provider
    always_comb begin
        if (h_prov == '0)
            amask = '1;
        else
            amask = ~((h_prov << 1) - NUM_TABLES'(1));
    end

    always_comb begin
        OUT_wrAddr   = '0;
        OUT_wrTag    = '0;
        OUT_wrTaken  = '0;
        OUT_wrValid  = '0;
        OUT_wrNew    = '0;
        OUT_wrUseful = '0;
        OUT_wrUpdate = '0;
        if (res && !rst) begin
            OUT_wrAddr   = q_idx_q[rd_ptr_q];
            OUT_wrTag    = q_tag_q[rd_ptr_q];
            OUT_wrTaken  = {NUM_TABLES{IN_resTaken}};
            OUT_wrValid  = h_prov;
            OUT_wrUpdate = h_prov;
            OUT_wrUseful = h_prov & {NUM_TABLES{q_ptk_q[rd_ptr_q] == IN_resTaken}};
            if (mispred) begin
                OUT_wrValid = h_prov | amask;
                OUT_wrNew   = amask;
            end
        end
    end

    assign OUT_anyAlloc = |(IN_wrAlloc & OUT_wrNew);

    always_comb begin
        hist_d = hist_q;
        if (mispred)
            hist_d = {q_snap_q[rd_ptr_q][GHIST_LEN-2:0], IN_resTaken};
        else if (accept)
            hist_d = {hist_q[GHIST_LEN-2:0], pred};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_id_q    <= '0;
        end else begin
            hist_q       <= hist_d;
            pred_valid_q <= push;
            if (push) begin
                pred_taken_q <= pred;
                pred_id_q    <= wr_ptr_q;
            end
            if (mispred) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (accept)
                    wr_ptr_q <= wr_ptr_q + ID_W'(1);
                if (res)
                    rd_ptr_q <= rd_ptr_q + ID_W'(1);
                count_q <= count_q + CNT_W'(accept) - CNT_W'(res);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_idx_q[wr_ptr_q]  <= rd_addr;
            q_tag_q[wr_ptr_q]  <= rd_tag;
            q_prov_q[wr_ptr_q] <= prov_oh;
            q_ptk_q[wr_ptr_q]  <= prov_tk;
            q_fin_q[wr_ptr_q]  <= pred;
            q_snap_q[wr_ptr_q] <= hist_q;
        end
    end

endmodule

// File: tb/tb_tage_pred_ctrl.sv
// Randomized scoreboard bench for tage_pred_ctrl against a queue-based
// reference model of the predictor, history and update rules.
module tb_tage_pred_ctrl;
    localparam int NT = 4;
    localparam int GL = 32;
    localparam int IW = 6;
    localparam int TWD = 8;
    localparam int DP = 8;

    logic              clk;
    logic              rst;
    logic              IN_reqValid;
    logic [31:0]       IN_reqPC;
    logic              IN_baseTaken;
    logic              OUT_reqReady;
    logic              OUT_predValid;
    logic              OUT_predTaken;
    logic [2:0]        OUT_predId;
    logic              IN_resValid;
    logic              IN_resTaken;
    logic [NT*IW-1:0]  OUT_rdAddr;
    logic [NT*TWD-1:0] OUT_rdTag;
    logic [NT-1:0]     IN_rdValid;
    logic [NT-1:0]     IN_rdTaken;
    logic [NT*IW-1:0]  OUT_wrAddr;
    logic [NT*TWD-1:0] OUT_wrTag;
    logic [NT-1:0]     OUT_wrTaken;
    logic [NT-1:0]     OUT_wrValid;
    logic [NT-1:0]     OUT_wrNew;
    logic [NT-1:0]     OUT_wrUseful;
    logic [NT-1:0]     OUT_wrUpdate;
    logic [NT-1:0]     IN_wrAlloc;
    logic              OUT_anyAlloc;

    tage_pred_ctrl #(
        .NUM_TABLES(NT), .GHIST_LEN(GL), .IDX_W(IW), .TAG_W(TWD), .DEPTH(DP)
    ) dut (
        .clk(clk), .rst(rst),
        .IN_reqValid(IN_reqValid), .IN_reqPC(IN_reqPC), .IN_baseTaken(IN_baseTaken),
        .OUT_reqReady(OUT_reqReady), .OUT_predValid(OUT_predValid),
        .OUT_predTaken(OUT_predTaken), .OUT_predId(OUT_predId),
        .IN_resValid(IN_resValid), .IN_resTaken(IN_resTaken),
        .OUT_rdAddr(OUT_rdAddr), .OUT_rdTag(OUT_rdTag),
        .IN_rdValid(IN_rdValid), .IN_rdTaken(IN_rdTaken),
        .OUT_wrAddr(OUT_wrAddr), .OUT_wrTag(OUT_wrTag), .OUT_wrTaken(OUT_wrTaken),
        .OUT_wrValid(OUT_wrValid), .OUT_wrNew(OUT_wrNew),
        .OUT_wrUseful(OUT_wrUseful), .OUT_wrUpdate(OUT_wrUpdate),
        .IN_wrAlloc(IN_wrAlloc), .OUT_anyAlloc(OUT_anyAlloc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NT*IW-1:0]  idx;
        logic [NT*TWD-1:0] tag;
        int                prov;
        bit                ptk;
        bit                fin;
        logic [31:0]       snap;
    } ent_t;

    typedef struct {
        bit       tk;
        int       id;
    } exp_t;

    ent_t        q[$];
    exp_t        expq[$];
    logic [31:0] hist;
    int          next_id;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Fold history as a sequence of w-bit chunks of the low L bits
    function automatic logic [31:0] fold(input logic [31:0] h, input int L, input int w);
        logic [63:0] v;
        logic [31:0] r;
        v = {32'd0, h} & ((64'd1 << L) - 64'd1);
        r = 32'd0;
        while (v != 64'd0) begin
            r = r ^ (v[31:0] & ((32'd1 << w) - 32'd1));
            v = v >> w;
        end
        return r;
    endfunction

    function automatic logic [31:0] hlen(input int t);
        return GL >> (NT - 1 - t);
    endfunction

    function automatic logic [IW-1:0] hidx(input logic [31:0] pc, input logic [31:0] h, input int t);
        logic [31:0] v;
        v = ((pc >> 2) & 32'h3f) ^ fold(h, hlen(t), IW);
        return v[IW-1:0];
    endfunction

    function automatic logic [TWD-1:0] htag(input logic [31:0] pc, input logic [31:0] h, input int t);
        logic [31:0] v;
        v = ((pc >> 8) & 32'hff) ^ fold(h, hlen(t), TWD);
        return v[TWD-1:0];
    endfunction

    // Monitor: every registered prediction must match the oldest pending expectation
    initial begin
        forever begin
            @(negedge clk);
            if (OUT_predValid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pred_unexpected: got valid id %0d expected none", OUT_predId);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("predTaken", 64'(OUT_predTaken), 64'(e.tk));
                    chk("predId", 64'(OUT_predId), 64'(e.id));
                end
            end else if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL pred_missing: got no valid expected id %0d", e.id);
            end
        end
    end

    task automatic cycle(input bit rv, input logic [31:0] pc, input bit base,
                         input logic [3:0] rdv, input logic [3:0] rdt,
                         input bit sv, input bit st, input logic [3:0] wa);
        logic [NT*IW-1:0]  e_ra, e_wa;
        logic [NT*TWD-1:0] e_rt, e_wt;
        logic [3:0] ev, en, eu, eup;
        bit   ready, res, mis, fin, ptk, acc;
        int   prov;
        ent_t h;
        @(negedge clk);
        #1;
        IN_reqValid  = rv;
        IN_reqPC     = pc;
        IN_baseTaken = base;
        IN_rdValid   = rdv;
        IN_rdTaken   = rdt;
        IN_resValid  = sv;
        IN_resTaken  = st;
        IN_wrAlloc   = wa;
        #1;
        ready = (q.size() < DP);
        chk("reqReady", 64'(OUT_reqReady), 64'(ready));
        for (int t = 0; t < NT; t++) begin
            e_ra[t*IW +: IW]   = hidx(pc, hist, t);
            e_rt[t*TWD +: TWD] = htag(pc, hist, t);
        end
        chk("rdAddr", 64'(OUT_rdAddr), 64'(e_ra));
        chk("rdTag", 64'(OUT_rdTag), 64'(e_rt));
        prov = -1;
        for (int t = NT - 1; t >= 0; t--) begin
            if (rdv[t]) begin
                prov = t;
                break;
            end
        end
        fin = (prov >= 0) ? rdt[prov] : base;
        ptk = (prov >= 0) ? rdt[prov] : 1'b0;
        res = sv && (q.size() > 0);
        ev = 4'd0; en = 4'd0; eu = 4'd0; eup = 4'd0;
        mis = 1'b0;
        if (res) begin
            h = q[0];
            mis = (h.fin != st);
            if (h.prov >= 0) begin
                ev[h.prov]  = 1'b1;
                eup[h.prov] = 1'b1;
                eu[h.prov]  = (h.ptk == st);
            end
            if (mis)
                for (int t = h.prov + 1; t < NT; t++) begin
                    ev[t] = 1'b1;
                    en[t] = 1'b1;
                end
            e_wa = h.idx;
            e_wt = h.tag;
            chk("wrAddr", 64'(OUT_wrAddr), 64'(e_wa));
            chk("wrTag", 64'(OUT_wrTag), 64'(e_wt));
            chk("wrTaken", 64'(OUT_wrTaken), st ? 64'hf : 64'h0);
        end
        chk("wrValid", 64'(OUT_wrValid), 64'(ev));
        chk("wrNew", 64'(OUT_wrNew), 64'(en));
        chk("wrUpdate", 64'(OUT_wrUpdate), 64'(eup));
        chk("wrUseful", 64'(OUT_wrUseful), 64'(eu));
        chk("anyAlloc", 64'(OUT_anyAlloc), 64'(|(en & wa)));
        acc = rv && ready;
        @(posedge clk);
        if (mis) begin
            q.delete();
            hist = {h.snap[30:0], st};
        end else begin
            if (res)
                void'(q.pop_front());
            if (acc) begin
                ent_t n;
                exp_t x;
                n.idx  = e_ra;
                n.tag  = e_rt;
                n.prov = prov;
                n.ptk  = ptk;
                n.fin  = fin;
                n.snap = hist;
                q.push_back(n);
                x.tk = fin;
                x.id = next_id;
                expq.push_back(x);
                next_id = (next_id + 1) % DP;
                hist = {hist[30:0], fin};
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        IN_reqValid = 1'b1;
        IN_resValid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_predValid", 64'(OUT_predValid), 64'd0);
        chk("rst_predTaken", 64'(OUT_predTaken), 64'd0);
        chk("rst_predId", 64'(OUT_predId), 64'd0);
        chk("rst_reqReady", 64'(OUT_reqReady), 64'd1);
        chk("rst_wr", 64'({OUT_wrValid, OUT_wrNew, OUT_wrUseful, OUT_wrUpdate, OUT_wrTaken}), 64'd0);
        chk("rst_anyAlloc", 64'(OUT_anyAlloc), 64'd0);
        q.delete();
        expq.delete();
        hist = 32'd0;
        next_id = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        IN_reqValid = 1'b0;
        IN_resValid = 1'b0;
    endtask

    function automatic bit head_fin();
        return (q.size() > 0) ? q[0].fin : 1'b0;
    endfunction

    initial begin
        rst = 1'b1;
        IN_reqValid = 1'b0; IN_reqPC = 32'd0; IN_baseTaken = 1'b0;
        IN_resValid = 1'b0; IN_resTaken = 1'b0;
        IN_rdValid = 4'd0; IN_rdTaken = 4'd0; IN_wrAlloc = 4'd0;
        hist = 32'd0;
        next_id = 0;
        repeat (2) @(posedge clk);
        apply_reset();

        // Directed: no-hit base prediction, provider update, full allocation
        cycle(1, 32'h100, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        cycle(0, 32'h100, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000);
        cycle(1, 32'h2468, 1, 4'b1010, 4'b0111, 0, 0, 4'b0000);
        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
        cycle(1, 32'h1234, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0100);
        cycle(1, 32'h100, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);

        // Directed: fill the queue, stall, then wrap the slot id
        apply_reset();
        for (int i = 0; i < 9; i++)
            cycle(1, 32'h40 * i, i[0], 4'($urandom), 4'($urandom), 0, 0, 4'b0000);
        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 1, head_fin(), 4'b0000);
        cycle(1, 32'hbeef0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000);

        // Directed: mispredict with younger entries and a same-cycle request
        apply_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h1000 + 32'h4 * i, 1, 4'b0010, 4'b0010, 0, 0, 4'b0000);
        cycle(1, 32'h5555, 1, 4'b0000, 4'b0000, 1, !head_fin(), 4'b1111);
        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            bit sv, st;
            if (i == 700)
                apply_reset();
            sv = ($urandom_range(0, 9) < 4);
            st = (q.size() > 0) ? (head_fin() ^ ($urandom_range(0, 3) == 0)) : 1'($urandom);
            cycle($urandom_range(0, 9) < 7, $urandom, 1'($urandom),
                  4'($urandom), 4'($urandom), sv, st, 4'($urandom));
        end

        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        cycle(0, 32'h0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        chk("pred_drain", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
